// File: rtl/sd_host_pkg.sv
// Shared SD host definitions: command FSM encoding, frame geometry, CRC7 polynomial
// and the default register_set addresses that the command path snoops.
package sd_host_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } sd_cmd_state_e;

    localparam int         CMD_FRAME_W      = 48;
    localparam logic [6:0] CRC7_POLY        = 7'h09;
    localparam logic [7:0] DEFAULT_ARG_ADDR = 8'h08;
    localparam logic [7:0] DEFAULT_CMD_ADDR = 8'h0C;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1) LFSR, one data bit per enable; shared by the command
// serializer and the response receiver.
module sd_crc7
    import sd_host_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic       feedback;

    always_comb begin
        feedback = din ^ crc_q[6];
        crc_d    = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_serializer.sv
// Snoops register_set writes to the Command dword, builds the 48-bit SD command frame
// (start, direction, index, argument, CRC7, end) and shifts it MSB-first onto CMD.
module sd_cmd_serializer
    import sd_host_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter logic [7:0]  ARG_ADDR = DEFAULT_ARG_ADDR,
    parameter logic [7:0]  CMD_ADDR = DEFAULT_CMD_ADDR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic          wnr,
    input  logic [7:0]    address,
    input  logic          ack,
    input  logic [2047:0] mem_data_out,
    output logic          sd_cmd_o,
    output logic          sd_cmd_oe,
    output logic          sd_clk_o,
    output logic          busy,
    output logic          done,
    output logic          overrun
);

    localparam int unsigned ARG_LSB  = 32'(ARG_ADDR) * 8;
    localparam int unsigned IDX_LSB  = 32'(CMD_ADDR) * 8 + 24;
    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0]  DIV_HALF = 8'(CLK_DIV / 2);
    localparam logic [5:0]  LAST_BIT = 6'(CMD_FRAME_W - 1);

    sd_cmd_state_e state_q, state_d;
    logic [5:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    div_cnt_q, div_cnt_d;
    logic [39:0]   frame_q, frame_d;
    logic          overrun_q, overrun_d;

    logic          trigger;
    logic          period_end;
    logic          crc_en;
    logic          tx_bit;
    logic [6:0]    crc;
    logic          unused_mem;

    assign trigger    = ack && wnr && (req != 2'b00) && (address == CMD_ADDR);
    assign period_end = (div_cnt_q == DIV_LAST);
    assign crc_en     = (state_q == SEND) && period_end && (bit_idx_q >= 6'd8);
    assign unused_mem = ^mem_data_out;

    // frame_q shifts left once per bit period, so bit 39 is always the data bit on the line
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        div_cnt_d = div_cnt_q;
        frame_d   = frame_q;
        overrun_d = overrun_q | (trigger && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                frame_d   = {1'b0, 1'b1, mem_data_out[IDX_LSB +: 6], mem_data_out[ARG_LSB +: 32]};
                bit_idx_d = LAST_BIT;
                div_cnt_d = '0;
                state_d   = SEND;
            end
            SEND: begin
                if (period_end) begin
                    div_cnt_d = '0;
                    frame_d   = {frame_q[38:0], 1'b0};
                    if (bit_idx_q == 6'd0) begin
                        state_d = DONE;
                    end else begin
                        bit_idx_d = bit_idx_q - 6'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            div_cnt_q <= '0;
            frame_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            div_cnt_q <= div_cnt_d;
            frame_q   <= frame_d;
            overrun_q <= overrun_d;
        end
    end

    sd_crc7 u_crc7 (
        .clk   (clk),
        .reset (reset),
        .clear (state_q == LOAD),
        .en    (crc_en),
        .din   (frame_q[39]),
        .crc   (crc)
    );

    // CRC finishes on the last period of bit 8, so it is stable for bits 7..1
    always_comb begin
        tx_bit = 1'b1;
        if (bit_idx_q >= 6'd8) begin
            tx_bit = frame_q[39];
        end else if (bit_idx_q != 6'd0) begin
            tx_bit = crc[bit_idx_q[2:0] - 3'd1];
        end
    end

    assign sd_cmd_oe = (state_q == SEND);
    assign sd_cmd_o  = (state_q == SEND) ? tx_bit : 1'b1;
    assign sd_clk_o  = (state_q == SEND) && (div_cnt_q >= DIV_HALF);
    assign busy      = (state_q == LOAD) || (state_q == SEND);
    assign done      = (state_q == DONE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sd_cmd_serializer.sv
// Directed bench for sd_cmd_serializer: table of known SD command frames plus
// hand-written overrun, reset-abort and no-trigger sequences.
module tb_sd_cmd_serializer;

    localparam int         CLK_DIV  = 2;
    localparam int         ARG_BYTE = 8;
    localparam int         CMD_BYTE = 12;
    localparam logic [7:0] ARG_ADDR = 8'h08;
    localparam logic [7:0] CMD_ADDR = 8'h0C;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    req = 2'b00;
    logic          wnr = 1'b0;
    logic [7:0]    address = 8'h00;
    logic          ack = 1'b0;
    logic [2047:0] mem_data_out = '0;
    logic          sd_cmd_o;
    logic          sd_cmd_oe;
    logic          sd_clk_o;
    logic          busy;
    logic          done;
    logic          overrun;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    sd_cmd_serializer #(
        .CLK_DIV  (CLK_DIV),
        .ARG_ADDR (ARG_ADDR),
        .CMD_ADDR (CMD_ADDR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .wnr          (wnr),
        .address      (address),
        .ack          (ack),
        .mem_data_out (mem_data_out),
        .sd_cmd_o     (sd_cmd_o),
        .sd_cmd_oe    (sd_cmd_oe),
        .sd_clk_o     (sd_clk_o),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    typedef struct {
        logic [31:0] arg;
        logic [31:0] cmd;
        logic [47:0] frame;
    } vec_t;

    task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
        total_cnt++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic setImage(input logic [31:0] arg, input logic [31:0] cmd);
        mem_data_out[ARG_BYTE*8 +: 32] = arg;
        mem_data_out[CMD_BYTE*8 +: 32] = cmd;
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic w, input logic [7:0] a, input logic k);
        req     = r;
        wnr     = w;
        address = a;
        ack     = k;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
        applyStimulus(2'b00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic runFrame(input logic [31:0] arg, input logic [31:0] cmd, input int inject_at,
                            output logic [47:0] frame, output int done_lat, output int busy_cyc,
                            output int rise_cnt, output int shape_err);
        int   oe_cyc;
        logic prev_clk;
        logic bit_val;
        frame     = '0;
        done_lat  = -1;
        busy_cyc  = 0;
        rise_cnt  = 0;
        shape_err = 0;
        oe_cyc    = 0;
        prev_clk  = 1'b0;
        bit_val   = 1'b0;
        setImage(arg, cmd);
        applyStimulus(2'b01, 1'b1, CMD_ADDR, 1'b1);
        for (int k = 1; k <= 400; k++) begin
            nextCycle();
            if (busy) busy_cyc++;
            if (sd_clk_o && !prev_clk) rise_cnt++;
            prev_clk = sd_clk_o;
            if (sd_cmd_oe) begin
                if (oe_cyc % CLK_DIV == 0) begin
                    bit_val = sd_cmd_o;
                    frame   = {frame[46:0], sd_cmd_o};
                end else if (sd_cmd_o !== bit_val) begin
                    shape_err++;
                end
                if (sd_clk_o !== ((oe_cyc % CLK_DIV) >= (CLK_DIV / 2))) shape_err++;
                oe_cyc++;
            end
            if (k == inject_at) begin
                setImage(32'hDEAD_BEEF, 32'h3F00_0000);
                applyStimulus(2'b11, 1'b1, CMD_ADDR, 1'b1);
            end
            if (done) begin
                if (sd_cmd_oe || !sd_cmd_o) shape_err++;
                done_lat = k;
                break;
            end
        end
        if (oe_cyc != 48 * CLK_DIV) shape_err++;
    endtask

    initial begin
        vec_t        vecs[4];
        logic [47:0] fr;
        int          lat;
        int          bcyc;
        int          rises;
        int          serr;
        int          seen;

        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 48'h40_0000_0000_95};
        vecs[1] = '{32'h0000_0000, 32'h1100_0000, 48'h51_0000_0000_55};
        vecs[2] = '{32'h0000_01AA, 32'h0800_0000, 48'h48_0000_01AA_87};
        vecs[3] = '{32'h0000_0000, 32'hF700_ABCD, 48'h77_0000_0000_65};

        reset = 1'b1;
        repeat (3) nextCycle();
        checkOutput("reset_outputs", {42'd0, sd_cmd_o, sd_cmd_oe, sd_clk_o, busy, done, overrun},
                    {42'd0, 6'b100000});
        reset = 1'b0;
        nextCycle();
        checkOutput("idle_outputs", {42'd0, sd_cmd_o, sd_cmd_oe, sd_clk_o, busy, done, overrun},
                    {42'd0, 6'b100000});

        for (int i = 0; i < 4; i++) begin
            runFrame(vecs[i].arg, vecs[i].cmd, 0, fr, lat, bcyc, rises, serr);
            checkOutput($sformatf("frame_%0d", i), fr, vecs[i].frame);
            checkOutput($sformatf("done_latency_%0d", i), 48'(lat), 48'(2 + 48 * CLK_DIV));
            checkOutput($sformatf("busy_cycles_%0d", i), 48'(bcyc), 48'(48 * CLK_DIV + 1));
            checkOutput($sformatf("sd_clk_rises_%0d", i), 48'(rises), 48'd48);
            checkOutput($sformatf("bit_shape_%0d", i), 48'(serr), 48'd0);
            nextCycle();
            checkOutput($sformatf("done_one_cycle_%0d", i), {47'd0, done}, 48'd0);
        end
        checkOutput("overrun_clear_after_frames", {47'd0, overrun}, 48'd0);

        // Read of CMD_ADDR and a write to ARG_ADDR must not start a frame
        setImage(32'h1234_5678, 32'h1100_0000);
        applyStimulus(2'b01, 1'b0, CMD_ADDR, 1'b1);
        nextCycle();
        applyStimulus(2'b01, 1'b1, ARG_ADDR, 1'b1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            nextCycle();
            if (sd_cmd_oe || busy) seen++;
        end
        checkOutput("no_trigger_read_or_arg", 48'(seen), 48'd0);

        // Second trigger and argument rewrite mid-frame
        runFrame(32'h0000_01AA, 32'h0800_0000, 50, fr, lat, bcyc, rises, serr);
        checkOutput("overrun_frame", fr, 48'h48_0000_01AA_87);
        checkOutput("overrun_latency", 48'(lat), 48'(2 + 48 * CLK_DIV));
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            nextCycle();
            if (sd_cmd_oe || busy) seen++;
        end
        checkOutput("overrun_no_second_frame", 48'(seen), 48'd0);
        checkOutput("overrun_sticky", {47'd0, overrun}, 48'd1);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        nextCycle();
        checkOutput("overrun_cleared_by_reset", {47'd0, overrun}, 48'd0);

        // Trigger landing in the DONE cycle
        runFrame(32'h0000_0000, 32'h0000_0000, 2 + 48 * CLK_DIV, fr, lat, bcyc, rises, serr);
        checkOutput("done_trigger_frame", fr, 48'h40_0000_0000_95);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            nextCycle();
            if (sd_cmd_oe || busy) seen++;
        end
        checkOutput("done_trigger_ignored", 48'(seen), 48'd0);
        checkOutput("done_trigger_overrun", {47'd0, overrun}, 48'd1);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;

        // Reset asserted while bit 20 is on the line
        setImage(32'h0000_01AA, 32'h0800_0000);
        applyStimulus(2'b01, 1'b1, CMD_ADDR, 1'b1);
        for (int k = 1; k <= 2 + (47 - 20) * CLK_DIV; k++) begin
            nextCycle();
        end
        checkOutput("abort_midframe_oe", {47'd0, sd_cmd_oe}, 48'd1);
        reset = 1'b1;
        nextCycle();
        checkOutput("abort_released", {44'd0, sd_cmd_oe, sd_cmd_o, busy, done}, {44'd0, 4'b0100});
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 120; k++) begin
            nextCycle();
            if (done || sd_cmd_oe || busy) seen++;
        end
        checkOutput("abort_no_done", 48'(seen), 48'd0);
        runFrame(32'h0000_0000, 32'h0000_0000, 0, fr, lat, bcyc, rises, serr);
        checkOutput("after_abort_crc", {41'd0, fr[7:1]}, 48'h4A);
        checkOutput("after_abort_frame", fr, 48'h40_0000_0000_95);
        checkOutput("after_abort_latency", 48'(lat), 48'(2 + 48 * CLK_DIV));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
